// File: rtl/psum_pkg.sv
// Shared widths, FSM encoding and the stage-B op record for the psum
// read-modify-write sequencer.
package psum_pkg;

   localparam int unsigned PSUM_DW = 40;
   localparam int unsigned PSUM_AW = 16;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   // Op held in stage B; fwd_val replaces the stale memory read when fwd_hit is set.
   typedef struct packed {
      logic [PSUM_AW-1:0] addr;
      logic [PSUM_DW-1:0] data;
      logic               first;
      logic               last;
      logic               fwd_hit;
      logic [PSUM_DW-1:0] fwd_val;
   } op_b_t;

endpackage

// File: rtl/psum_out_reg.sv
// Single-entry valid/ready holding register for final sums; reloads in the
// same cycle it is drained so back-to-back results see no bubble.
module psum_out_reg
   import psum_pkg::*;
#(
   parameter int unsigned DW = PSUM_DW,
   parameter int unsigned AW = PSUM_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] data_i,
   input  logic          ready_i,
   output logic          valid_o,
   output logic [AW-1:0] addr_o,
   output logic [DW-1:0] data_o
);

   logic          valid_q, valid_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         addr_d  = addr_i;
         data_d  = data_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign addr_o  = addr_q;
   assign data_o  = data_q;

endmodule

// File: rtl/psum_rmw_ctrl.sv
// Read-modify-write sequencer for the partial-sum memory: two-stage accumulate
// pipeline with same-address forwarding, final-sum output port and zero-fill sweep.
module psum_rmw_ctrl
   import psum_pkg::*;
#(
   parameter int unsigned DW = PSUM_DW,
   parameter int unsigned AW = PSUM_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_start,
   input  logic [AW-1:0] clr_len,
   output logic          busy,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] in_addr,
   input  logic [DW-1:0] in_data,
   input  logic          in_first,
   input  logic          in_last,
   output logic          mem_re,
   output logic [AW-1:0] mem_ra,
   input  logic [DW-1:0] mem_rd,
   output logic          mem_we,
   output logic [AW-1:0] mem_wa,
   output logic [DW-1:0] mem_wd,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_addr,
   output logic [DW-1:0] out_data
);

   state_e        state_q, state_d;
   logic [AW-1:0] clr_cnt_q, clr_cnt_d;
   logic [AW-1:0] clr_len_q, clr_len_d;
   logic          clr_pend_q, clr_pend_d;
   logic          b_valid_q, b_valid_d;
   op_b_t         b_q, b_d;

   logic          stall;
   logic          clr_req;
   logic          clr_want;
   logic          accept;
   logic          b_fire;
   logic          out_load;
   logic [DW-1:0] old_val;
   logic [DW-1:0] sum;

   // Stage-B arithmetic and pipeline handshakes.
   always_comb begin
      stall    = b_valid_q & b_q.last & out_valid & ~out_ready;
      clr_req  = clr_start & (clr_len != '0) & (state_q == ST_IDLE);
      clr_want = clr_req | clr_pend_q;
      in_ready = ~stall & (state_q == ST_IDLE) & ~clr_want;
      accept   = in_valid & in_ready;
      b_fire   = b_valid_q & ~stall;
      out_load = b_fire & b_q.last;
      old_val  = b_q.first ? '0 : (b_q.fwd_hit ? b_q.fwd_val : mem_rd);
      sum      = old_val + b_q.data;
      busy     = (state_q != ST_IDLE) | b_valid_q | clr_pend_q;
   end

   // FSM next state: a clear waits for stage B to drain before sweeping.
   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      clr_len_d  = clr_len_q;
      clr_pend_d = clr_pend_q;
      unique case (state_q)
         ST_IDLE: begin
            if (clr_want) begin
               clr_len_d = clr_pend_q ? clr_len_q : clr_len;
               if (!b_valid_q) begin
                  state_d    = ST_CLEAR;
                  clr_cnt_d  = '0;
                  clr_pend_d = 1'b0;
               end else begin
                  clr_pend_d = 1'b1;
               end
            end
         end
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + AW'(1);
            if (clr_cnt_q == clr_len_q - AW'(1)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Stage-B register update and memory port drive.
   always_comb begin
      b_valid_d = b_valid_q;
      b_d       = b_q;
      mem_re    = 1'b0;
      mem_ra    = '0;
      mem_we    = 1'b0;
      mem_wa    = '0;
      mem_wd    = '0;

      if (accept) begin
         mem_re      = ~in_first;
         mem_ra      = in_first ? '0 : in_addr;
         b_valid_d   = 1'b1;
         b_d.addr    = in_addr;
         b_d.data    = in_data;
         b_d.first   = in_first;
         b_d.last    = in_last;
         b_d.fwd_hit = b_fire & (b_q.addr == in_addr);
         b_d.fwd_val = sum;
      end else if (b_fire) begin
         b_valid_d = 1'b0;
      end

      if (state_q == ST_CLEAR) begin
         mem_we = 1'b1;
         mem_wa = clr_cnt_q;
      end else if (b_fire) begin
         mem_we = 1'b1;
         mem_wa = b_q.addr;
         mem_wd = sum;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         clr_cnt_q  <= '0;
         clr_len_q  <= '0;
         clr_pend_q <= 1'b0;
         b_valid_q  <= 1'b0;
         b_q        <= '0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         clr_len_q  <= clr_len_d;
         clr_pend_q <= clr_pend_d;
         b_valid_q  <= b_valid_d;
         b_q        <= b_d;
      end
   end

   psum_out_reg #(
      .DW (DW),
      .AW (AW)
   ) u_out_reg (
      .clk     (clk),
      .rst     (rst),
      .load_i  (out_load),
      .addr_i  (b_q.addr),
      .data_i  (sum),
      .ready_i (out_ready),
      .valid_o (out_valid),
      .addr_o  (out_addr),
      .data_o  (out_data)
   );

endmodule

// File: tb/tb_psum_rmw_ctrl.sv
// Self-checking bench for psum_rmw_ctrl: behavioural psum memory, table of
// accumulate vectors, hand sequences for clear/stall/reset, scoreboard on out_*.
module tb_psum_rmw_ctrl;
   import psum_pkg::*;

   localparam int unsigned DW = PSUM_DW;
   localparam int unsigned AW = PSUM_AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clr_start = 1'b0;
   logic [AW-1:0] clr_len = '0;
   logic          busy;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] in_addr = '0;
   logic [DW-1:0] in_data = '0;
   logic          in_first = 1'b0;
   logic          in_last = 1'b0;
   logic          mem_re;
   logic [AW-1:0] mem_ra;
   logic [DW-1:0] mem_rd = '0;
   logic          mem_we;
   logic [AW-1:0] mem_wa;
   logic [DW-1:0] mem_wd;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_data;

   psum_rmw_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .clr_start (clr_start),
      .clr_len   (clr_len),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_addr   (in_addr),
      .in_data   (in_data),
      .in_first  (in_first),
      .in_last   (in_last),
      .mem_re    (mem_re),
      .mem_ra    (mem_ra),
      .mem_rd    (mem_rd),
      .mem_we    (mem_we),
      .mem_wa    (mem_wa),
      .mem_wd    (mem_wd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   // Behavioural psum memory: registered read, read-before-write at one edge.
   logic [DW-1:0] mem [0:65535];
   logic          bd_en = 1'b0;
   logic [AW-1:0] bd_addr = '0;
   logic [DW-1:0] bd_data = '0;

   always @(posedge clk) begin
      if (mem_re) mem_rd <= mem[mem_ra];
      if (mem_we) mem[mem_wa] <= mem_wd;
      if (bd_en)  mem[bd_addr] <= bd_data;
   end

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      bit            first;
      bit            last;
      logic [DW-1:0] exp;
   } vec_t;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   rnd_mode = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic backdoor(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bd_addr = a;
      bd_data = d;
      bd_en   = 1'b1;
      tick();
      bd_en   = 1'b0;
   endtask

   // Offer one op, wait (bounded) for acceptance, and queue its expected result.
   task automatic send_op(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit f, input bit l, input logic [DW-1:0] e);
      bit acc = 1'b0;
      int n   = 0;
      exp_t x;
      in_addr  = a;
      in_data  = d;
      in_first = f;
      in_last  = l;
      in_valid = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         tick();
         n++;
      end
      in_valid = 1'b0;
      if (!acc) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: addr 0x%0h never accepted", a);
      end else if (l) begin
         x.a = a;
         x.d = e;
         sb_q.push_back(x);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      chk("drain", 64'(sb_q.size()), 64'(0));
   endtask

   // Scoreboard: every handshake on out_* must match the oldest expected result.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL out_unexpected: addr 0x%0h data 0x%0h with empty queue", out_addr, out_data);
         end else begin
            mon_e = sb_q.pop_front();
            chk("out_addr", 64'(out_addr), 64'(mon_e.a));
            chk("out_data", 64'(out_data), 64'(mon_e.d));
         end
      end
   end

   vec_t          tbl [8];
   logic [DW-1:0] refm [4];
   bit            refv [4];

   initial begin
      tbl[0] = '{addr: 16'd5, data: 40'd10,            first: 1, last: 0, exp: 40'd0};
      tbl[1] = '{addr: 16'd5, data: 40'd7,             first: 0, last: 0, exp: 40'd0};
      tbl[2] = '{addr: 16'd5, data: 40'hFF_FFFF_FFFD,  first: 0, last: 1, exp: 40'd14};
      tbl[3] = '{addr: 16'd8, data: 40'h12,            first: 1, last: 1, exp: 40'h12};
      tbl[4] = '{addr: 16'd9, data: 40'hFF_FFFF_FFFF,  first: 1, last: 0, exp: 40'd0};
      tbl[5] = '{addr: 16'd8, data: 40'd1,             first: 0, last: 1, exp: 40'h13};
      tbl[6] = '{addr: 16'd9, data: 40'd2,             first: 0, last: 1, exp: 40'd1};
      tbl[7] = '{addr: 16'd5, data: 40'd6,             first: 0, last: 1, exp: 40'd20};

      // Reset state.
      repeat (3) tick();
      rst = 1'b0;
      #1;
      chk("rst_busy",      64'(busy),      64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_mem_we",    64'(mem_we),    64'(0));
      chk("rst_mem_re",    64'(mem_re),    64'(0));
      chk("rst_mem_wa",    64'(mem_wa),    64'(0));
      chk("rst_mem_wd",    64'(mem_wd),    64'(0));
      chk("rst_out_data",  64'(out_data),  64'(0));
      chk("rst_in_ready",  64'(in_ready),  64'(1));

      // Table vectors, back to back, including double forwarding on address 5.
      for (int i = 0; i < 8; i++) begin
         send_op(tbl[i].addr, tbl[i].data, tbl[i].first, tbl[i].last, tbl[i].exp);
      end
      drain();

      // Latency: write one cycle after accept, out_valid one cycle later.
      send_op(16'd20, 40'd5, 1'b1, 1'b1, 40'd5);
      chk("lat_mem_we",    64'(mem_we),    64'(1));
      chk("lat_mem_wa",    64'(mem_wa),    64'(20));
      chk("lat_mem_wd",    64'(mem_wd),    64'(5));
      chk("lat_out_early", 64'(out_valid), 64'(0));
      tick();
      chk("lat_out_valid", 64'(out_valid), 64'(1));
      drain();

      // Zero-fill of four words, then a read-accumulate over a cleared word.
      backdoor(16'd2, 40'h55);
      clr_len   = 16'd4;
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("clr_we",       64'(mem_we),   64'(1));
         chk("clr_wa",       64'(mem_wa),   64'(i));
         chk("clr_wd",       64'(mem_wd),   64'(0));
         chk("clr_in_ready", 64'(in_ready), 64'(0));
         tick();
      end
      @(negedge clk);
      chk("clr_done_we",   64'(mem_we), 64'(0));
      chk("clr_done_busy", 64'(busy),   64'(0));
      tick();
      send_op(16'd2, 40'd9, 1'b0, 1'b1, 40'd9);
      drain();

      // Modulo-2^40 wrap.
      backdoor(16'd1, 40'h7F_FFFF_FFFF);
      send_op(16'd1, 40'd1, 1'b0, 1'b1, 40'h80_0000_0000);
      drain();

      // Output back-pressure with two last ops in flight.
      backdoor(16'd3, 40'd50);
      backdoor(16'd4, 40'd1000);
      out_ready = 1'b0;
      send_op(16'd3, 40'd100, 1'b0, 1'b1, 40'd150);
      send_op(16'd4, 40'd200, 1'b0, 1'b1, 40'd1200);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_in_ready", 64'(in_ready), 64'(0));
         chk("stall_mem_we",   64'(mem_we),   64'(0));
         chk("stall_mem_re",   64'(mem_re),   64'(0));
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("unstall_we", 64'(mem_we), 64'(1));
      chk("unstall_wa", 64'(mem_wa), 64'(4));
      chk("unstall_wd", 64'(mem_wd), 64'(1200));
      tick();
      drain();

      // Clear requested while stage B holds an op; held output stays put.
      out_ready = 1'b0;
      send_op(16'd30, 40'd77, 1'b1, 1'b1, 40'd77);
      send_op(16'd7, 40'd3, 1'b1, 1'b0, 40'd0);
      clr_len   = 16'd2;
      clr_start = 1'b1;
      @(negedge clk);
      chk("pend_b_we", 64'(mem_we), 64'(1));
      chk("pend_b_wa", 64'(mem_wa), 64'(7));
      chk("pend_b_wd", 64'(mem_wd), 64'(3));
      tick();
      clr_start = 1'b0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (mem_we) break;
         tick();
      end
      chk("pend_clr_we0", 64'(mem_we), 64'(1));
      chk("pend_clr_wa0", 64'(mem_wa), 64'(0));
      chk("pend_clr_wd0", 64'(mem_wd), 64'(0));
      tick();
      @(negedge clk);
      chk("pend_clr_wa1",  64'(mem_wa),   64'(1));
      chk("pend_clr_rdy",  64'(in_ready), 64'(0));
      tick();
      @(negedge clk);
      chk("pend_clr_end",  64'(mem_we), 64'(0));
      chk("pend_mem7",     64'(mem[7]), 64'(3));

      // Reset in the middle of a longer sweep.
      tick();
      clr_len   = 16'd8;
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      tick();
      tick();
      chk("midclr_busy",  64'(busy),      64'(1));
      chk("midclr_outv",  64'(out_valid), 64'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb_q.delete();
      chk("rstclr_we",   64'(mem_we),    64'(0));
      chk("rstclr_busy", 64'(busy),      64'(0));
      chk("rstclr_outv", 64'(out_valid), 64'(0));
      out_ready = 1'b1;

      // Random accumulate traffic with random back-pressure against a reference model.
      for (int i = 0; i < 4; i++) refv[i] = 1'b0;
      rnd_mode = 1'b1;
      for (int k = 0; k < 60; k++) begin
         int            idx;
         bit            f;
         bit            l;
         logic [DW-1:0] d;
         logic [DW-1:0] e;
         idx = $urandom_range(0, 3);
         f   = !refv[idx] || ($urandom_range(0, 4) == 0);
         l   = ($urandom_range(0, 1) == 1);
         d   = DW'({$urandom(), $urandom()});
         e   = (f ? '0 : refm[idx]) + d;
         refm[idx] = e;
         refv[idx] = 1'b1;
         send_op(AW'(10 + idx), d, f, l, e);
         if ($urandom_range(0, 3) == 0) tick();
      end
      rnd_mode  = 1'b0;
      out_ready = 1'b1;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/psum_rmw_ctrl.md
Name: psum_rmw_ctrl

Overview:
Read-modify-write sequencer in front of the partial-sum memory (`psum`: 40-bit data, 16-bit address, registered read with 1-cycle latency).
- Accepts partial sums from the PE array, one per cycle.
- Reads the stored psum, adds the new value and writes the result back.
- Forwards read-after-write hazards itself.
- Emits final sums to the output stage on a valid/ready port.
- Also provides a zero-fill sweep that clears a psum region before each layer.

Parameters:
DW, 40, psum data width (input, memory and output)
AW, 16, psum address width

Ports:
clk  in  1  clock; every register updates on its rising edge
rst  in  1  reset, synchronous, active-high
clr_start  in  1  1-cycle pulse: start zero-fill of addresses 0..clr_len-1; ignored unless FSM is IDLE
clr_len  in  AW  number of words to clear; 0 means no-op
busy  out  1  high when FSM is not IDLE or any pipeline stage is valid
in_valid  in  1  partial sum offered
in_ready  out  1  partial sum accepted when in_valid & in_ready
in_addr  in  AW  psum address
in_data  in  DW  partial sum, two's complement
in_first  in  1  first pass: overwrite, ignore stored value
in_last  in  1  last pass: also emit the result on out_*
mem_re  out  1  psum read enable
mem_ra  out  AW  psum read address
mem_rd  in  DW  psum read data; valid the cycle after mem_re
mem_we  out  1  psum write enable
mem_wa  out  AW  psum write address
mem_wd  out  DW  psum write data
out_valid  out  1  final sum available
out_ready  in  1  downstream accepts
out_addr  out  AW  address of the final sum
out_data  out  DW  final sum

Behaviour:
- Reset values:
  - FSM = IDLE; stage A/B valids, out_valid and busy = 0.
  - mem_re = mem_we = 0; all address/data outputs = 0.
  - A reset asserted mid-operation abandons in-flight ops without writing them. Memory contents are undefined afterwards.
- FSM states:
  - IDLE -> CLEAR on clr_start with clr_len != 0 and both pipeline stages empty. If the pipeline is not empty, the pulse is latched and CLEAR starts once the pipeline drains.
  - CLEAR -> IDLE after writing address clr_len-1.
  - CLEAR behaviour: in_ready = 0, mem_re = 0; writes mem_we = 1, mem_wa = counter (0, 1, ...), mem_wd = 0, one word per cycle. Takes clr_len cycles.
- Pipeline (IDLE only):
  - Stage A is the accept cycle. mem_re = ~in_first, mem_ra = in_addr; the op's addr/data/first/last flags are registered into stage B.
  - Stage B is the next cycle. old = in_first ? 0 : (fwd_hit ? fwd_val : mem_rd). sum = old + data, modulo 2^DW (wrap, no saturation). Same cycle: mem_we = 1, mem_wa = addr, mem_wd = sum.
- Hazard forwarding:
  - Trigger: op accepted in A at cycle t while B holds the same address.
  - Effect: B's sum from cycle t is captured as fwd_val with fwd_hit = 1 for the new op. The memory read is stale (write lands at the same edge).
  - Back-to-back updates to one address therefore sustain 1 op/cycle.
- Output:
  - When a B op has last = 1, {addr, sum} loads into the out register and out_valid is set. The out register holds until out_valid & out_ready.
  - stall = B.valid & B.last & out_valid & ~out_ready.
  - During stall: B holds and performs no write; mem_re = 0, so the memory keeps its read data; in_ready = 0.
  - When not stalled: in_ready = (FSM == IDLE) & ~clr_pending.
- Latency: accept -> memory write 1 cycle; accept -> out_valid 2 cycles. Throughput is 1 op/cycle with no stall.
- If out_valid & out_ready occur while a new last op is in B, the out register reloads the same cycle with no bubble.

Decomposition:
- A shared package `psum_pkg` holds:
  - PSUM_DW = 40, PSUM_AW = 16.
  - FSM state encoding (IDLE, CLEAR).
  - The stage-B op struct fields: addr, data, first, last, fwd_hit, fwd_val.
- One natural sub-module: `psum_out_reg`, the single-entry valid/ready holding register for {out_addr, out_data}.

Test Plan:
- Ops {A=5, d=10, first}, then {5, 7}, then {5, -3, last} on consecutive cycles -> out_addr = 5, out_data = 14, with out_valid 2 cycles after the third accept. Covers forwarding twice.
- clr_start, clr_len = 4 -> mem_we 4 cycles at wa = 0..3 with wd = 0; in_ready = 0 throughout; then busy = 0. A later non-first op {2, 9, last} -> out = 9.
- Mem holds 0x7F_FFFF_FFFF at address 1; op {1, 1, last} -> out_data = 0x80_0000_0000 (wrap).
- out_ready = 0 with last ops to addresses 3 and 4 in flight -> in_ready drops, no second write until out_ready = 1. Then addr 3 then addr 4 emerge in order with correct sums.
- clr_start while the pipeline holds an op -> the pending write completes first, then the clear starts. rst asserted mid-CLEAR -> next cycle mem_we = 0, busy = 0, out_valid = 0.
